// File: rtl/sdio_pixel_packer.sv
// Packs a stream of SDIO payload bytes into RGB565 pixels and issues one
// registered framebuffer write per completed pixel, tracking frame progress.
module sdio_pixel_packer #(
  parameter int FRAME_PIXELS = 384000,
  parameter int ADDR_WIDTH   = 19,
  parameter int BYTE_SWAP    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic [15:0]           fb_data_out,
  output logic                  fb_wr_en,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  frame_abort,
  output logic [1:0]            fsm_state
);

  // Handshake: byte_valid qualifies byte_data for exactly one cycle and there
  // is no ready/backpressure; frame_start outranks byte_valid in the same cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] pix_idx, idx_next;
  logic [7:0]            first_byte, first_next;
  logic [15:0]           data_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  wr_next;
  logic                  done_next;
  logic                  abort_next;
  logic                  ovf_next;

  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pix_idx     <= '0;
      first_byte  <= 8'h00;
      fb_data_out <= 16'h0000;
      fb_addr     <= '0;
      fb_wr_en    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_next;
      pix_idx     <= idx_next;
      first_byte  <= first_next;
      fb_data_out <= data_next;
      fb_addr     <= addr_next;
      fb_wr_en    <= wr_next;
      frame_done  <= done_next;
      frame_abort <= abort_next;
      overflow    <= ovf_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = pix_idx;
    first_next = first_byte;
    data_next  = fb_data_out;
    addr_next  = fb_addr;
    wr_next    = 1'b0;
    done_next  = 1'b0;
    abort_next = 1'b0;
    ovf_next   = overflow;

    if (frame_start) begin
      // A pixel completed last cycle is already in the output registers, so
      // restarting here never loses it; only a half pixel is dropped.
      state_next = FIRST;
      idx_next   = '0;
      ovf_next   = 1'b0;
      abort_next = (state == SECOND) || ((state == FIRST) && (pix_idx != '0));
    end else if (byte_valid) begin
      case (state)
        FIRST: begin
          first_next = byte_data;
          state_next = SECOND;
        end
        SECOND: begin
          wr_next   = 1'b1;
          addr_next = pix_idx;
          if (BYTE_SWAP != 0) data_next = {first_byte, byte_data};
          else                data_next = {byte_data, first_byte};
          if (pix_idx == LAST_ADDR) begin
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            idx_next   = pix_idx + 1'b1;
            state_next = FIRST;
          end
        end
        default: ovf_next = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_sdio_pixel_packer.sv
// Directed bench for sdio_pixel_packer: a small frame size, both byte orders,
// and an expected-write queue per instance drained by a negedge monitor.
module tb_sdio_pixel_packer;

  localparam int FP = 6;
  localparam int AW = 3;
  localparam int W  = 1 + AW + 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;

  logic [15:0] data0, data1;
  logic wr0, wr1, done0, done1, ovf0, ovf1, abort0, abort1;
  logic [AW-1:0] addr0, addr1;
  logic [1:0] st0, st1;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int errors = 0;
  int checks = 0;
  int abort_cnt0 = 0;
  int abort_cnt1 = 0;

  sdio_pixel_packer #(.FRAME_PIXELS(FP), .ADDR_WIDTH(AW), .BYTE_SWAP(0)) dut0 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .fb_data_out(data0), .fb_wr_en(wr0), .fb_addr(addr0),
    .frame_done(done0), .overflow(ovf0), .frame_abort(abort0), .fsm_state(st0)
  );

  sdio_pixel_packer #(.FRAME_PIXELS(FP), .ADDR_WIDTH(AW), .BYTE_SWAP(1)) dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .fb_data_out(data1), .fb_wr_en(wr1), .fb_addr(addr1),
    .frame_done(done1), .overflow(ovf1), .frame_abort(abort1), .fsm_state(st1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // drivers: inputs change 1ns after the rising edge and are held one cycle
  task automatic drive(input logic fs, input logic bv, input logic [7:0] b);
    frame_start = fs;
    byte_valid  = bv;
    byte_data   = b;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    byte_valid  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b0, 1'b1, b);
  endtask

  task automatic start();
    drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic expect_pix(input int a, input logic [7:0] b0, input logic [7:0] b1, input logic last);
    exp_q0.push_back({last, AW'(a), b1, b0});
    exp_q1.push_back({last, AW'(a), b0, b1});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr"},    {wr1, wr0}, 0);
    check({tag, "_addr"},  {addr1, addr0}, 0);
    check({tag, "_data"},  {data1, data0}, 0);
    check({tag, "_done"},  {done1, done0}, 0);
    check({tag, "_abort"}, {abort1, abort0}, 0);
    check({tag, "_ovf"},   {ovf1, ovf0}, 0);
    check({tag, "_state"}, {st1, st0}, 0);
  endtask

  // scoreboard: every observed write must match the head of its queue
  always @(negedge clk) begin
    if (abort0) abort_cnt0++;
    if (abort1) abort_cnt1++;
    if (wr0) begin
      if (exp_q0.size() == 0) check("unexpected_wr0", 1, 0);
      else check("wr0", {done0, addr0, data0}, exp_q0.pop_front());
    end else if (done0) check("stray_done0", 1, 0);
    if (wr1) begin
      if (exp_q1.size() == 0) check("unexpected_wr1", 1, 0);
      else check("wr1", {done1, addr1, data1}, exp_q1.pop_front());
    end else if (done1) check("stray_done1", 1, 0);
  end

  initial begin
    // reset state, with a byte presented that must be ignored
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    rst = 1'b0;
    idle(1);

    // basic packing: 0x34,0x12 -> 0x1234 at 0, then a gapped pixel at 1
    start();
    expect_pix(0, 8'h34, 8'h12, 1'b0);
    send(8'h34);
    send(8'h12);
    expect_pix(1, 8'h78, 8'h56, 1'b0);
    send(8'h78);
    idle(3);
    send(8'h56);
    idle(2);
    check("basic_q_drained", exp_q0.size() + exp_q1.size(), 0);
    check("basic_no_abort", abort_cnt0, 0);

    // restart mid-frame at address 2, then again with a half pixel latched
    start();
    expect_pix(0, 8'h11, 8'h22, 1'b0);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    start();
    expect_pix(0, 8'h44, 8'h55, 1'b0);
    send(8'h44);
    send(8'h55);
    idle(2);
    check("abort_count_2", abort_cnt0, 2);
    check("abort_no_ovf", {ovf1, ovf0}, 0);

    // frame_start together with a byte: the byte is discarded
    drive(1'b1, 1'b1, 8'hEE);
    expect_pix(0, 8'h66, 8'h77, 1'b0);
    send(8'h66);
    send(8'h77);
    idle(2);
    check("same_cycle_abort", abort_cnt0, 3);
    check("same_cycle_ovf", {ovf1, ovf0}, 0);

    // complete frame with gaps, then one surplus byte
    start();
    for (int i = 0; i < FP; i++) begin
      expect_pix(i, 8'hA0 + 8'(i), 8'h50 + 8'(i), i == FP - 1);
      send(8'hA0 + 8'(i));
      idle(i % 2);
      send(8'h50 + 8'(i));
      idle((i + 1) % 3);
    end
    idle(1);
    check("full_q_drained", exp_q0.size() + exp_q1.size(), 0);
    check("full_state_done", {st1, st0}, {2'd3, 2'd3});
    check("full_no_ovf", {ovf1, ovf0}, 0);
    send(8'hFF);
    idle(2);
    check("surplus_ovf", {ovf1, ovf0}, 2'b11);
    check("surplus_abort_count", abort_cnt0, 4);

    // restart from DONE: no abort, overflow cleared
    start();
    idle(1);
    check("done_restart_abort", abort_cnt0, 4);
    check("done_restart_ovf", {ovf1, ovf0}, 0);

    // reset while holding a half pixel: frame dropped, later bytes overflow
    send(8'h99);
    check("pre_rst_state", st0, 2);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h12);
    idle(2);
    check("post_rst_ovf", {ovf1, ovf0}, 2'b11);
    check("post_rst_state", {st1, st0}, 0);

    // write from a pixel completed just before frame_start is still issued
    start();
    expect_pix(0, 8'h01, 8'h02, 1'b0);
    send(8'h01);
    send(8'h02);
    start();
    expect_pix(0, 8'h03, 8'h04, 1'b0);
    send(8'h03);
    send(8'h04);
    idle(2);
    check("pending_q_drained", exp_q0.size() + exp_q1.size(), 0);
    check("pending_abort_count", abort_cnt0, 5);
    check("abort_agree", abort_cnt1, abort_cnt0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
